// File: rtl/msk_stall_pkg.sv
// Shared types for the masked-core randomness stalling controller.
// Exports the controller state enum and watchdog counter sizing.
package msk_stall_pkg;

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        READY  = 2'd1,
        RUN    = 2'd2,
        ERR    = 2'd3
    } state_t;

    localparam int STALL_TIMEOUT_DEF = 64;

    // Watchdog counter must be able to hold the timeout value itself.
    function automatic int wd_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int WD_W_DEF = $clog2(STALL_TIMEOUT_DEF + 1);

endpackage

// File: rtl/msk_stall_chan.sv
// Per-channel slice: ok term plus consume/refill PRNG run requests.
// Ports: glob, in_run, warmup, need, valid -> ok, use_en, refill_en.
module msk_stall_chan
    import msk_stall_pkg::*;
(
    input  logic glob,
    input  logic in_run,
    input  logic warmup,
    input  logic need,
    input  logic valid,
    output logic ok,
    output logic use_en,
    output logic refill_en
);

    assign ok        = ~need | valid;
    // use_en is qualified by the all-channel ok in the top.
    assign use_en    = glob & in_run & need;
    assign refill_en = glob & (in_run | warmup) & ~valid;

endmodule

// File: rtl/msk_rnd_stall_ctrl.sv
// Stalls a masked core until every needed PRNG channel is valid.
// Ports: clk/pre_syn_rst, glob, start, need/valid -> enables, status.
module msk_rnd_stall_ctrl
    import msk_stall_pkg::*;
#(
    parameter int NCH           = 2,
    parameter int STALL_TIMEOUT = STALL_TIMEOUT_DEF,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             pre_syn_rst,
    input  logic             pre_enable_glob,
    input  logic             pre_data_in_valid,
    input  logic [NCH-1:0]   pre_need_rnd,
    input  logic [NCH-1:0]   rnd_valid_next_enable,
    input  logic             core_in_process,
    output logic             pre_enable_core,
    output logic [NCH-1:0]   pre_enable_run_prng,
    output logic             ready_start_run,
    output logic             data_in_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             err_timeout
);

    localparam int WD_W = wd_width(STALL_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(STALL_TIMEOUT - 1);

    state_t state_q;
    state_t state_d;

    logic [WD_W-1:0] wd_q;
    logic            cip_q;

    logic           glob;
    logic           in_run;
    logic           warmup;
    logic           ok_all;
    logic           stall;
    logic           accept;
    logic           fall;
    logic           timeout;
    logic [NCH-1:0] ok_c;
    logic [NCH-1:0] use_c;
    logic [NCH-1:0] refill_c;

    // Reset also gates every combinational enable.
    assign glob   = pre_enable_glob & ~pre_syn_rst;
    assign in_run = (state_q == RUN);
    assign warmup = (state_q == WARMUP);

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        msk_stall_chan u_chan (
            .glob      (glob),
            .in_run    (in_run),
            .warmup    (warmup),
            .need      (pre_need_rnd[c]),
            .valid     (rnd_valid_next_enable[c]),
            .ok        (ok_c[c]),
            .use_en    (use_c[c]),
            .refill_en (refill_c[c])
        );
    end

    assign ok_all  = &ok_c;
    assign stall   = in_run & glob & ~ok_all;
    assign accept  = (state_q == READY) & glob & pre_data_in_valid;
    // cip_q is cleared on accept, so the first run cycle never ends a run.
    assign fall    = in_run & glob & cip_q & ~core_in_process;
    assign timeout = stall & (wd_q >= WD_LAST);

    // A channel that is stalled runs once for refill only.
    assign pre_enable_run_prng = refill_c | (use_c & {NCH{ok_all}});

    always_comb begin
        state_d         = state_q;
        pre_enable_core = 1'b0;
        ready_start_run = 1'b0;
        unique case (state_q)
            WARMUP: begin
                if (glob && (&rnd_valid_next_enable))
                    state_d = READY;
            end
            READY: begin
                ready_start_run = glob;
                if (accept)
                    state_d = RUN;
            end
            RUN: begin
                pre_enable_core = glob & ok_all;
                if (timeout)
                    state_d = ERR;
                else if (fall)
                    state_d = WARMUP;
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = WARMUP;
            end
        endcase
    end

    always_ff @(posedge clk or posedge pre_syn_rst) begin
        if (pre_syn_rst) begin
            state_q       <= WARMUP;
            data_in_valid <= 1'b0;
            stall_cnt     <= '0;
            err_timeout   <= 1'b0;
            wd_q          <= '0;
            cip_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            data_in_valid <= accept;
            if (state_d == ERR)
                err_timeout <= 1'b1;
            if (accept)
                stall_cnt <= '0;
            else if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (accept || (in_run && glob && ok_all))
                wd_q <= '0;
            else if (stall && (wd_q != '1))
                wd_q <= wd_q + 1'b1;
            if (glob)
                cip_q <= in_run & core_in_process;
        end
    end

endmodule

// File: tb/tb_msk_rnd_stall_ctrl.sv
// Directed vector bench for msk_rnd_stall_ctrl (NCH=2, timeout 8).
// Inputs are driven on the falling edge and checked 1ns later.
module tb_msk_rnd_stall_ctrl;

    typedef struct {
        bit        rst;
        bit        g;
        bit        dv;
        bit [1:0]  need;
        bit [1:0]  vld;
        bit        cip;
        bit [21:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        glob = 1'b0;
    logic        dv = 1'b0;
    logic [1:0]  need = 2'b00;
    logic [1:0]  vld = 2'b00;
    logic        cip = 1'b0;
    logic        core;
    logic [1:0]  prng;
    logic        rdy;
    logic        div;
    logic [15:0] cnt;
    logic        err;

    int total = 0;
    int bad   = 0;

    vec_t vq[$];

    always #5 clk = ~clk;

    msk_rnd_stall_ctrl #(
        .NCH           (2),
        .STALL_TIMEOUT (8),
        .CNT_W         (16)
    ) dut (
        .clk                   (clk),
        .pre_syn_rst           (rst),
        .pre_enable_glob       (glob),
        .pre_data_in_valid     (dv),
        .pre_need_rnd          (need),
        .rnd_valid_next_enable (vld),
        .core_in_process       (cip),
        .pre_enable_core       (core),
        .pre_enable_run_prng   (prng),
        .ready_start_run       (rdy),
        .data_in_valid         (div),
        .stall_cnt             (cnt),
        .err_timeout           (err)
    );

    function automatic vec_t mk(
        bit r, bit g, bit d, bit [1:0] n, bit [1:0] v, bit c,
        bit e_core, bit [1:0] e_prng, bit e_rdy, bit e_div,
        bit e_err, int e_cnt
    );
        vec_t t;
        t.rst  = r;
        t.g    = g;
        t.dv   = d;
        t.need = n;
        t.vld  = v;
        t.cip  = c;
        t.exp  = {e_core, e_prng, e_rdy, e_div, e_err, 16'(e_cnt)};
        return t;
    endfunction

    task automatic apply(input vec_t t, input string name);
        logic [21:0] act;
        @(negedge clk);
        rst  = t.rst;
        glob = t.g;
        dv   = t.dv;
        need = t.need;
        vld  = t.vld;
        cip  = t.cip;
        #1;
        act = {core, prng, rdy, div, err, cnt};
        total++;
        if (act !== t.exp) begin
            bad++;
            $display("FAIL %s: got core/prng/rdy/div/err/cnt=%b/%b/%b/%b/%b/%0d want %b/%b/%b/%b/%b/%0d",
                name, act[21], act[20:19], act[18], act[17], act[16],
                act[15:0], t.exp[21], t.exp[20:19], t.exp[18],
                t.exp[17], t.exp[16], t.exp[15:0]);
        end
    endtask

    initial begin
        // reset, warm-up refill, start handshake
        vq.push_back(mk(1,1,0,2'b00,2'b00,0, 0,2'b00,0,0,0,0));
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(0,1,0,2'b00,2'b00,0, 0,2'b11,0,0,0,0));
        vq.push_back(mk(0,1,0,2'b00,2'b11,0, 0,2'b00,0,0,0,0));
        vq.push_back(mk(0,1,0,2'b00,2'b11,0, 0,2'b00,1,0,0,0));
        vq.push_back(mk(0,1,1,2'b00,2'b11,0, 0,2'b00,1,0,0,0));
        vq.push_back(mk(0,1,0,2'b00,2'b11,0, 1,2'b00,0,1,0,0));
        // channel 1 stall for 5 cycles
        for (int i = 0; i < 5; i++)
            vq.push_back(mk(0,1,0,2'b10,2'b01,1, 0,2'b10,0,0,0,i));
        vq.push_back(mk(0,1,0,2'b10,2'b11,1, 1,2'b10,0,0,0,5));
        // glob freeze mid-stall
        vq.push_back(mk(0,1,0,2'b01,2'b10,1, 0,2'b01,0,0,0,5));
        for (int i = 0; i < 4; i++)
            vq.push_back(mk(0,0,0,2'b01,2'b10,1, 0,2'b00,0,0,0,6));
        vq.push_back(mk(0,1,0,2'b01,2'b10,1, 0,2'b01,0,0,0,6));
        vq.push_back(mk(0,1,0,2'b01,2'b10,1, 0,2'b01,0,0,0,7));
        // run end on core_in_process falling, refill channel 0
        vq.push_back(mk(0,1,0,2'b00,2'b11,0, 1,2'b00,0,0,0,8));
        vq.push_back(mk(0,1,0,2'b00,2'b10,0, 0,2'b01,0,0,0,8));
        vq.push_back(mk(0,1,0,2'b00,2'b11,0, 0,2'b00,0,0,0,8));
        vq.push_back(mk(0,1,1,2'b00,2'b11,0, 0,2'b00,1,0,0,8));
        // channel 0 stall up to the watchdog
        for (int i = 0; i < 8; i++)
            vq.push_back(mk(0,1,0,2'b01,2'b10,1, 0,2'b01,0,i==0,0,i));
        vq.push_back(mk(0,1,0,2'b01,2'b10,1, 0,2'b00,0,0,1,8));
        vq.push_back(mk(0,1,1,2'b00,2'b11,0, 0,2'b00,0,0,1,8));
        vq.push_back(mk(1,1,0,2'b00,2'b11,0, 0,2'b00,0,0,0,0));

        foreach (vq[i])
            apply(vq[i], $sformatf("vec%0d", i));

        // timeout coinciding with run end: ERR wins
        apply(mk(0,1,0,2'b00,2'b11,0, 0,2'b00,0,0,0,0), "err_warm");
        apply(mk(0,1,1,2'b00,2'b11,0, 0,2'b00,1,0,0,0), "err_start");
        for (int i = 0; i < 7; i++)
            apply(mk(0,1,0,2'b01,2'b10,1, 0,2'b01,0,i==0,0,i),
                $sformatf("err_stall%0d", i));
        apply(mk(0,1,0,2'b01,2'b10,0, 0,2'b01,0,0,0,7), "err_both");
        apply(mk(0,1,0,2'b01,2'b10,0, 0,2'b00,0,0,1,8), "err_wins");

        // reset asserted mid-run
        apply(mk(1,1,0,2'b00,2'b11,0, 0,2'b00,0,0,0,0), "mr_rst");
        apply(mk(0,1,0,2'b00,2'b11,0, 0,2'b00,0,0,0,0), "mr_warm");
        apply(mk(0,1,1,2'b00,2'b11,0, 0,2'b00,1,0,0,0), "mr_start");
        apply(mk(0,1,0,2'b10,2'b01,1, 0,2'b10,0,1,0,0), "mr_stall0");
        apply(mk(0,1,0,2'b10,2'b01,1, 0,2'b10,0,0,0,1), "mr_stall1");
        apply(mk(1,1,0,2'b10,2'b01,1, 0,2'b00,0,0,0,0), "mr_async");
        apply(mk(0,1,0,2'b00,2'b00,0, 0,2'b11,0,0,0,0), "mr_rewarm");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msk_rnd_stall_ctrl.md
Name: msk_rnd_stall_ctrl

Overview:
Generalised stalling/scheduling controller between a masked core (Clyde-class) and NCH PRNG randomness channels. It gates the core enable whenever any channel the core needs next cycle has no valid randomness, and drives per-channel PRNG run enables for both consumption and refill. It owns the start handshake. Beyond the fixed two-channel stalling unit, it adds a warm-up refill phase, a stall watchdog with a sticky error, and a saturating stall-cycle counter.

Parameters:
NCH, 2, number of PRNG randomness channels (1..8)
STALL_TIMEOUT, 64, consecutive stall cycles in RUN that trigger ERR (>=2)
CNT_W, 16, width of stall_cnt

Ports:
clk  input  1  clock, all state on rising edge
pre_syn_rst  input  1  reset, asynchronous, active-high
pre_enable_glob  input  1  global enable; 0 freezes the controller
pre_data_in_valid  input  1  start request from the host
pre_need_rnd  input  NCH  core needs channel c randomness on its next enabled cycle
rnd_valid_next_enable  input  NCH  channel c holds valid randomness for its next run
core_in_process  input  1  core busy status
pre_enable_core  output  1  core clock-enable
pre_enable_run_prng  output  NCH  per-channel PRNG run enable
ready_start_run  output  1  controller accepts a start
data_in_valid  output  1  registered single-cycle start pulse to the core
stall_cnt  output  CNT_W  stall cycles in the current run, saturating
err_timeout  output  1  sticky watchdog error

Behaviour:
- Reset, async: state WARMUP; data_in_valid=0; stall_cnt=0; err_timeout=0; internal stall counter=0. The combinational outputs pre_enable_core, ready_start_run and pre_enable_run_prng evaluate to 0 while reset is asserted.
- States: WARMUP, READY, RUN, ERR.
- pre_enable_glob=0 (any state):
  - all enables 0, ready_start_run=0;
  - state and counters hold;
  - data_in_valid is not generated.
- WARMUP:
  - pre_enable_run_prng[c] = glob & ~rnd_valid_next_enable[c];
  - pre_enable_core=0;
  - moves to READY when all rnd_valid_next_enable=1 and glob=1.
- READY:
  - ready_start_run=glob;
  - pre_data_in_valid & glob: data_in_valid=1 on the next cycle for exactly 1 cycle; stall_cnt cleared; state moves to RUN.
  - Otherwise pre_data_in_valid is ignored, including in all other states (no queueing).
- RUN:
  - ok = AND over c of (~pre_need_rnd[c] | rnd_valid_next_enable[c]);
  - pre_enable_core = glob & ok;
  - pre_enable_run_prng[c] = glob & ((ok & pre_need_rnd[c]) | ~rnd_valid_next_enable[c]), i.e. consume on use, refill when empty, never run a valid channel that the core is not consuming.
- Stall cycle = RUN & glob & ~ok:
  - increments stall_cnt, saturating at 2^CNT_W-1;
  - increments the consecutive counter, which clears on any glob & ok cycle.
- Consecutive counter reaching STALL_TIMEOUT: next state ERR.
- Run end: in RUN, core_in_process sampled 1 then 0 (falling edge, registered) moves to WARMUP. The first cycle after data_in_valid does not count as an edge even if core_in_process is still 0.
- ERR:
  - err_timeout=1;
  - all enables 0, ready_start_run=0;
  - exits only via reset.
- Simultaneous events:
  - a timeout and a run end in the same cycle: ERR wins.
  - pre_need_rnd while a channel refills in the same cycle: the channel runs once; the core stalls.
- Reset mid-run: immediate return to WARMUP; stall_cnt and err_timeout cleared.
- Latency: start pulse is 1 cycle after acceptance. The enable paths are combinational from the inputs and state register.

Decomposition:
- Package msk_stall_pkg: state enum (WARMUP, READY, RUN, ERR) and a localparam for the watchdog counter width, $clog2(STALL_TIMEOUT+1).
- One sub-module msk_stall_chan, instantiated NCH times via generate. It computes the channel ok term and its PRNG run enable from glob, in_run, warmup, need and valid.

Test Plan:
- NCH=2, reset released, valid=2'b00 for 3 cycles then 2'b11 -> prng enables 2'b11 for 3 cycles, then READY, ready_start_run=1.
- READY, pre_data_in_valid=1 for 1 cycle -> data_in_valid=1 exactly one cycle later, state RUN, stall_cnt=0.
- RUN, need=2'b10, valid=2'b01 for 5 cycles -> pre_enable_core=0, prng[1]=1, stall_cnt=5. Then valid=2'b11 -> core enabled.
- STALL_TIMEOUT=8, channel 0 held invalid with need=2'b01 for 8 cycles -> err_timeout=1 sticky, all enables 0 until reset.
- pre_enable_glob=0 for 4 cycles mid-stall -> stall_cnt frozen, all enables 0. Resumes counting on glob=1.
- core_in_process 1->0 with valid=2'b10 -> WARMUP, prng[0]=1 until valid, then ready_start_run=1. Reset asserted mid-RUN -> outputs 0 in the same cycle.
